// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern generator: mode codes, sync
// polarity constants and the band colour palette.
package vga_pkg;

    localparam logic [1:0] MODE_HBAND    = 2'd0;
    localparam logic [1:0] MODE_VBAND    = 2'd1;
    localparam logic [1:0] MODE_CHECKER  = 2'd2;
    localparam logic [1:0] MODE_GRADIENT = 2'd3;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    // Which channels are driven full-scale for a palette entry
    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_sel_t;

    localparam int unsigned PALETTE_LEN = 7;

    localparam rgb_sel_t PALETTE [PALETTE_LEN] = '{
        '{r: 1'b1, g: 1'b0, b: 1'b0},   // red
        '{r: 1'b0, g: 1'b1, b: 1'b0},   // green
        '{r: 1'b0, g: 1'b0, b: 1'b1},   // blue
        '{r: 1'b1, g: 1'b1, b: 1'b0},   // yellow
        '{r: 1'b0, g: 1'b1, b: 1'b1},   // cyan
        '{r: 1'b1, g: 1'b0, b: 1'b1},   // magenta
        '{r: 1'b1, g: 1'b1, b: 1'b1}    // white
    };

    // Band index is at most 15, so mod 7 needs only two conditional subtracts
    function automatic rgb_sel_t band_colour(input logic [3:0] band);
        logic [3:0] k;
        k = band;
        if (k >= 4'd14) begin
            k = k - 4'd14;
        end else if (k >= 4'd7) begin
            k = k - 4'd7;
        end
        return PALETTE[3'(k)];
    endfunction

endpackage

// File: rtl/vga_band_step.sv
// Step counter: advances idx once every STEP advance pulses, saturating at MAX.
// Replaces a divide-by-constant for band and gradient indices.
module vga_band_step #(
    parameter int unsigned STEP  = 1,
    parameter int unsigned MAX   = 1,
    parameter int unsigned IDX_W = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] idx
);

    localparam int unsigned CNT_W = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP - 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(MAX);

    logic [CNT_W-1:0] cnt;

    // Clear dominates advance so a coincident restart lands on index 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (clear) begin
            cnt <= '0;
            idx <= '0;
        end else if (advance) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                if (idx != IDX_MAX) begin
                    idx <= idx + 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator: colours each active pixel from the incoming sync/DE
// stream and re-emits sync/DE with the same one-cycle delay as the RGB.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned COLOR_W   = 4,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned NUM_BANDS = 3,
    parameter int unsigned CHK_LOG2  = 5,
    parameter logic        SYNC_ACT  = SYNC_ACTIVE_LOW
) (
    input  logic               pixel_clk,
    input  logic               rst,
    input  logic               hs_i,
    input  logic               vs_i,
    input  logic               de_i,
    input  logic [1:0]         mode_i,
    output logic               hs_o,
    output logic               vs_o,
    output logic               de_o,
    output logic [COLOR_W-1:0] red_o,
    output logic [COLOR_W-1:0] green_o,
    output logic [COLOR_W-1:0] blue_o
);

    localparam int unsigned XW = ($clog2(H_ACTIVE) > CHK_LOG2) ? $clog2(H_ACTIVE) : CHK_LOG2 + 1;
    localparam int unsigned YW = ($clog2(V_ACTIVE) > CHK_LOG2) ? $clog2(V_ACTIVE) : CHK_LOG2 + 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    localparam int unsigned BAND_W    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int unsigned H_BW      = (H_ACTIVE / NUM_BANDS > 0) ? H_ACTIVE / NUM_BANDS : 1;
    localparam int unsigned V_BW      = (V_ACTIVE / NUM_BANDS > 0) ? V_ACTIVE / NUM_BANDS : 1;
    localparam int unsigned GRAD_STEP = ((H_ACTIVE >> COLOR_W) > 0) ? (H_ACTIVE >> COLOR_W) : 1;
    localparam int unsigned GRAD_MAX  = (2 ** COLOR_W) - 1;

    localparam logic [COLOR_W-1:0] FULL = '1;

    logic              de_q;
    logic              vs_act_q;
    logic              vs_act;
    logic              frame_start;
    logic              de_fall;
    logic [XW-1:0]     x_cnt;
    logic [YW-1:0]     y_cnt;
    logic [1:0]        mode_q;
    logic [BAND_W-1:0] hband_idx;
    logic [BAND_W-1:0] vband_idx;
    logic [COLOR_W-1:0] grad_idx;

    logic [COLOR_W-1:0] red_c;
    logic [COLOR_W-1:0] green_c;
    logic [COLOR_W-1:0] blue_c;
    rgb_sel_t           sel_c;

    assign vs_act      = (vs_i == SYNC_ACT);
    assign frame_start = vs_act & ~vs_act_q;
    assign de_fall     = de_q & ~de_i;

    // vs_act_q resets "active" so a sync already asserted at release is not a new frame
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            de_q     <= 1'b0;
            vs_act_q <= 1'b1;
        end else begin
            de_q     <= de_i;
            vs_act_q <= vs_act;
        end
    end

    // x_cnt holds the index of the pixel currently on de_i
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            x_cnt <= '0;
        end else if (!de_i) begin
            x_cnt <= '0;
        end else if (x_cnt != X_LAST) begin
            x_cnt <= x_cnt + 1'b1;
        end
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            y_cnt  <= '0;
            mode_q <= MODE_HBAND;
        end else if (frame_start) begin
            y_cnt  <= '0;
            mode_q <= mode_i;
        end else if (de_fall && (y_cnt != Y_LAST)) begin
            y_cnt <= y_cnt + 1'b1;
        end
    end

    // Horizontal steppers are held clear through blanking so pixel 0 sees index 0
    vga_band_step #(
        .STEP  (H_BW),
        .MAX   (NUM_BANDS - 1),
        .IDX_W (BAND_W)
    ) u_hband (
        .clk     (pixel_clk),
        .rst     (rst),
        .clear   (~de_i),
        .advance (de_i),
        .idx     (hband_idx)
    );

    vga_band_step #(
        .STEP  (V_BW),
        .MAX   (NUM_BANDS - 1),
        .IDX_W (BAND_W)
    ) u_vband (
        .clk     (pixel_clk),
        .rst     (rst),
        .clear   (frame_start),
        .advance (de_fall),
        .idx     (vband_idx)
    );

    vga_band_step #(
        .STEP  (GRAD_STEP),
        .MAX   (GRAD_MAX),
        .IDX_W (COLOR_W)
    ) u_grad (
        .clk     (pixel_clk),
        .rst     (rst),
        .clear   (~de_i),
        .advance (de_i),
        .idx     (grad_idx)
    );

    // Colour of the pixel presented on de_i this cycle
    always_comb begin
        red_c   = '0;
        green_c = '0;
        blue_c  = '0;
        sel_c   = '0;
        case (mode_q)
            MODE_HBAND:   sel_c = band_colour(4'(vband_idx));
            MODE_VBAND:   sel_c = band_colour(4'(hband_idx));
            MODE_CHECKER: begin
                if (x_cnt[CHK_LOG2] ^ y_cnt[CHK_LOG2]) begin
                    sel_c = '1;
                end
            end
            default:      red_c = grad_idx;
        endcase
        if (sel_c.r) red_c   = FULL;
        if (sel_c.g) green_c = FULL;
        if (sel_c.b) blue_c  = FULL;
        if (!de_i) begin
            red_c   = '0;
            green_c = '0;
            blue_c  = '0;
        end
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            hs_o    <= 1'b0;
            vs_o    <= 1'b0;
            de_o    <= 1'b0;
            red_o   <= '0;
            green_o <= '0;
            blue_o  <= '0;
        end else begin
            hs_o    <= hs_i;
            vs_o    <= vs_i;
            de_o    <= de_i;
            red_o   <= red_c;
            green_o <= green_c;
            blue_o  <= blue_c;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: a default instance plus a NUM_BANDS=7,
// CHK_LOG2=0 instance fed the same sync/DE stream.
module tb_vga_pattern_gen;

    logic       pixel_clk;
    logic       rst;
    logic       hs_i;
    logic       vs_i;
    logic       de_i;
    logic [1:0] mode_i;

    logic       hs_o, vs_o, de_o;
    logic [3:0] red_o, green_o, blue_o;
    logic       hs7, vs7, de7;
    logic [3:0] red7, green7, blue7;

    int vectors     = 0;
    int miscompares = 0;

    vga_pattern_gen dut (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .hs_i      (hs_i),
        .vs_i      (vs_i),
        .de_i      (de_i),
        .mode_i    (mode_i),
        .hs_o      (hs_o),
        .vs_o      (vs_o),
        .de_o      (de_o),
        .red_o     (red_o),
        .green_o   (green_o),
        .blue_o    (blue_o)
    );

    vga_pattern_gen #(
        .NUM_BANDS (7),
        .CHK_LOG2  (0)
    ) dut7 (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .hs_i      (hs_i),
        .vs_i      (vs_i),
        .de_i      (de_i),
        .mode_i    (mode_i),
        .hs_o      (hs7),
        .vs_o      (vs7),
        .de_o      (de7),
        .red_o     (red7),
        .green_o   (green7),
        .blue_o    (blue7)
    );

    initial begin
        pixel_clk = 1'b0;
        forever #5 pixel_clk = ~pixel_clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] pal(input int k);
        case (k % 7)
            0:       return 12'hF00;
            1:       return 12'h0F0;
            2:       return 12'h00F;
            3:       return 12'hFF0;
            4:       return 12'h0FF;
            5:       return 12'hF0F;
            default: return 12'hFFF;
        endcase
    endfunction

    // 3 bands of 160 lines; y saturates at 479
    function automatic logic [11:0] hband3(input int y);
        if (y < 160) return 12'hF00;
        if (y < 320) return 12'h0F0;
        return 12'h00F;
    endfunction

    // 7 bands of 68 lines, remainder joins band 6
    function automatic logic [11:0] hband7(input int y);
        int b;
        b = y / 68;
        if (b > 6) b = 6;
        return pal(b);
    endfunction

    task automatic drive(input logic de, input logic hs, input logic vs);
        de_i = de;
        hs_i = hs;
        vs_i = vs;
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic hblank();
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
    endtask

    task automatic vsync_start();
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        mode_i = 2'd2;
        de_i = 1'b1; hs_i = 1'b0; vs_i = 1'b0;
        #1;
        vectors++;
        if ({de_o, hs_o, vs_o, red_o, green_o, blue_o} !== 15'h0) begin
            miscompares++;
            $display("FAIL reset_hold: got %h want %h", {de_o, hs_o, vs_o, red_o, green_o, blue_o}, 15'h0);
        end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        vectors++;
        if ({de_o, hs_o, vs_o, red_o, green_o, blue_o, de7, red7, green7, blue7} !== 28'h0) begin
            miscompares++;
            $display("FAIL reset_clocked: got %h/%h want 0", {de_o, hs_o, vs_o, red_o, green_o, blue_o},
                     {de7, red7, green7, blue7});
        end
        drive(1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b1);
        vectors++;
        if ({de_o, hs_o, vs_o, red_o, green_o, blue_o} !== {3'b011, 12'h000}) begin
            miscompares++;
            $display("FAIL reset_release: got %h want %h", {de_o, hs_o, vs_o, red_o, green_o, blue_o},
                     {3'b011, 12'h000});
        end
        // No frame start yet: mode stays 0 even though mode_i=2
        for (int x = 0; x < 40; x++) begin
            drive(1'b1, 1'b1, 1'b1);
            vectors++;
            if ({de_o, red_o, green_o, blue_o, de7, red7, green7, blue7} !== {1'b1, 12'hF00, 1'b1, 12'hF00}) begin
                miscompares++;
                $display("FAIL reset_mode0 x=%0d: got %h/%h want 1f00", x, {de_o, red_o, green_o, blue_o},
                         {de7, red7, green7, blue7});
            end
        end
        hblank();
    endtask

    task automatic test_hbands();
        logic [11:0] e3, e7;
        logic hs_pat;
        mode_i = 2'd0;
        vsync_start();
        for (int y = 0; y < 484; y++) begin
            e3 = hband3(y);
            e7 = hband7(y > 479 ? 479 : y);
            for (int x = 0; x < 8; x++) begin
                drive(1'b1, 1'b1, 1'b1);
                vectors++;
                if ({de_o, hs_o, vs_o, red_o, green_o, blue_o} !== {3'b111, e3}) begin
                    miscompares++;
                    $display("FAIL hband y=%0d x=%0d: got %h want %h", y, x,
                             {de_o, hs_o, vs_o, red_o, green_o, blue_o}, {3'b111, e3});
                end
                vectors++;
                if ({de7, red7, green7, blue7} !== {1'b1, e7}) begin
                    miscompares++;
                    $display("FAIL hband7 y=%0d x=%0d: got %h want %h", y, x, {de7, red7, green7, blue7}, {1'b1, e7});
                end
            end
            for (int b = 0; b < 4; b++) begin
                hs_pat = (b == 1 || b == 2) ? 1'b0 : 1'b1;
                drive(1'b0, hs_pat, 1'b1);
                vectors++;
                if ({de_o, hs_o, vs_o, red_o, green_o, blue_o} !== {1'b0, hs_pat, 1'b1, 12'h000}) begin
                    miscompares++;
                    $display("FAIL hband_blank y=%0d b=%0d: got %h want %h", y, b,
                             {de_o, hs_o, vs_o, red_o, green_o, blue_o}, {1'b0, hs_pat, 1'b1, 12'h000});
                end
            end
        end
    endtask

    task automatic test_vbands();
        logic [11:0] e3, e7;
        int b7;
        mode_i = 2'd1;
        vsync_start();
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 640; x++) begin
                e3 = (x < 213) ? 12'hF00 : (x < 426) ? 12'h0F0 : 12'h00F;
                b7 = x / 91;
                if (b7 > 6) b7 = 6;
                e7 = pal(b7);
                drive(1'b1, 1'b1, 1'b1);
                vectors++;
                if ({de_o, red_o, green_o, blue_o} !== {1'b1, e3}) begin
                    miscompares++;
                    $display("FAIL vband y=%0d x=%0d: got %h want %h", y, x, {de_o, red_o, green_o, blue_o}, {1'b1, e3});
                end
                vectors++;
                if ({de7, red7, green7, blue7} !== {1'b1, e7}) begin
                    miscompares++;
                    $display("FAIL vband7 y=%0d x=%0d: got %h want %h", y, x, {de7, red7, green7, blue7}, {1'b1, e7});
                end
            end
            hblank();
        end
    endtask

    task automatic test_checker();
        logic [11:0] e5, e0;
        mode_i = 2'd2;
        vsync_start();
        for (int y = 0; y < 67; y++) begin
            // Line 66 follows a frame start that coincided with a DE falling edge
            int yy;
            yy = (y == 66) ? 0 : y;
            for (int x = 0; x < 70; x++) begin
                e5 = ((((x >> 5) ^ (yy >> 5)) & 1) != 0) ? 12'hFFF : 12'h000;
                e0 = (((x ^ yy) & 1) != 0) ? 12'hFFF : 12'h000;
                drive(1'b1, 1'b1, 1'b1);
                vectors++;
                if ({de_o, red_o, green_o, blue_o} !== {1'b1, e5}) begin
                    miscompares++;
                    $display("FAIL checker y=%0d x=%0d: got %h want %h", y, x, {de_o, red_o, green_o, blue_o}, {1'b1, e5});
                end
                vectors++;
                if ({de7, red7, green7, blue7} !== {1'b1, e0}) begin
                    miscompares++;
                    $display("FAIL checker0 y=%0d x=%0d: got %h want %h", y, x, {de7, red7, green7, blue7}, {1'b1, e0});
                end
            end
            if (y == 65) begin
                drive(1'b0, 1'b1, 1'b0);
                vectors++;
                if ({de_o, vs_o, red_o, green_o, blue_o} !== {2'b00, 12'h000}) begin
                    miscompares++;
                    $display("FAIL checker_vs: got %h want %h", {de_o, vs_o, red_o, green_o, blue_o}, {2'b00, 12'h000});
                end
                drive(1'b0, 1'b1, 1'b0);
                drive(1'b0, 1'b1, 1'b1);
                drive(1'b0, 1'b1, 1'b1);
            end else begin
                hblank();
            end
        end
    endtask

    task automatic test_gradient();
        logic [3:0] lvl;
        mode_i = 2'd3;
        vsync_start();
        for (int x = 0; x < 640; x++) begin
            lvl = 4'((x / 40 > 15) ? 15 : x / 40);
            drive(1'b1, 1'b1, 1'b1);
            vectors++;
            if ({de_o, red_o, green_o, blue_o} !== {1'b1, lvl, 8'h00}) begin
                miscompares++;
                $display("FAIL gradient x=%0d: got %h want %h", x, {de_o, red_o, green_o, blue_o}, {1'b1, lvl, 8'h00});
            end
            vectors++;
            if ({de7, red7, green7, blue7} !== {1'b1, lvl, 8'h00}) begin
                miscompares++;
                $display("FAIL gradient7 x=%0d: got %h want %h", x, {de7, red7, green7, blue7}, {1'b1, lvl, 8'h00});
            end
        end
        hblank();
        for (int x = 0; x < 10; x++) begin
            drive(1'b1, 1'b1, 1'b1);
            vectors++;
            if ({de_o, red_o, green_o, blue_o} !== {1'b1, 12'h000}) begin
                miscompares++;
                $display("FAIL gradient_restart x=%0d: got %h want %h", x, {de_o, red_o, green_o, blue_o}, {1'b1, 12'h000});
            end
        end
        hblank();
    endtask

    task automatic test_mode_midframe();
        logic [11:0] e3, e7, e5, e0;
        mode_i = 2'd0;
        vsync_start();
        for (int y = 0; y < 480; y++) begin
            if (y == 200) mode_i = 2'd2;
            e3 = hband3(y);
            e7 = hband7(y);
            for (int x = 0; x < 40; x++) begin
                drive(1'b1, 1'b1, 1'b1);
                vectors++;
                if ({de_o, red_o, green_o, blue_o} !== {1'b1, e3}) begin
                    miscompares++;
                    $display("FAIL midframe y=%0d x=%0d: got %h want %h", y, x, {de_o, red_o, green_o, blue_o}, {1'b1, e3});
                end
                vectors++;
                if ({de7, red7, green7, blue7} !== {1'b1, e7}) begin
                    miscompares++;
                    $display("FAIL midframe7 y=%0d x=%0d: got %h want %h", y, x, {de7, red7, green7, blue7}, {1'b1, e7});
                end
            end
            hblank();
        end
        vsync_start();
        for (int x = 0; x < 40; x++) begin
            e5 = (((x >> 5) & 1) != 0) ? 12'hFFF : 12'h000;
            e0 = ((x & 1) != 0) ? 12'hFFF : 12'h000;
            drive(1'b1, 1'b1, 1'b1);
            vectors++;
            if ({de_o, red_o, green_o, blue_o} !== {1'b1, e5}) begin
                miscompares++;
                $display("FAIL nextframe x=%0d: got %h want %h", x, {de_o, red_o, green_o, blue_o}, {1'b1, e5});
            end
            vectors++;
            if ({de7, red7, green7, blue7} !== {1'b1, e0}) begin
                miscompares++;
                $display("FAIL nextframe7 x=%0d: got %h want %h", x, {de7, red7, green7, blue7}, {1'b1, e0});
            end
        end
        hblank();
    endtask

    task automatic test_reset_midline();
        logic [11:0] e5;
        logic hs_pat;
        mode_i = 2'd2;
        vsync_start();
        for (int y = 0; y < 300; y++) begin
            for (int x = 0; x < 8; x++) drive(1'b1, 1'b1, 1'b1);
            hblank();
        end
        // y=300 has bit 5 set, so x<32 is white
        for (int x = 0; x < 100; x++) begin
            e5 = ((((x >> 5) ^ (300 >> 5)) & 1) != 0) ? 12'hFFF : 12'h000;
            drive(1'b1, 1'b1, 1'b1);
            vectors++;
            if ({de_o, red_o, green_o, blue_o} !== {1'b1, e5}) begin
                miscompares++;
                $display("FAIL line300 x=%0d: got %h want %h", x, {de_o, red_o, green_o, blue_o}, {1'b1, e5});
            end
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({de_o, hs_o, vs_o, red_o, green_o, blue_o, de7, hs7, vs7, red7, green7, blue7} !== 30'h0) begin
            miscompares++;
            $display("FAIL async_reset: got %h/%h want 0", {de_o, hs_o, vs_o, red_o, green_o, blue_o},
                     {de7, hs7, vs7, red7, green7, blue7});
        end
        drive(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        for (int x = 0; x < 20; x++) begin
            drive(1'b1, 1'b1, 1'b1);
            vectors++;
            if ({de_o, hs_o, vs_o, red_o, green_o, blue_o} !== {3'b111, 12'hF00}) begin
                miscompares++;
                $display("FAIL post_reset x=%0d: got %h want %h", x, {de_o, hs_o, vs_o, red_o, green_o, blue_o},
                         {3'b111, 12'hF00});
            end
        end
        for (int b = 0; b < 4; b++) begin
            hs_pat = (b == 1 || b == 2) ? 1'b0 : 1'b1;
            drive(1'b0, hs_pat, 1'b1);
            vectors++;
            if ({de_o, hs_o, vs_o, red_o, green_o, blue_o} !== {1'b0, hs_pat, 1'b1, 12'h000}) begin
                miscompares++;
                $display("FAIL post_reset_blank b=%0d: got %h want %h", b,
                         {de_o, hs_o, vs_o, red_o, green_o, blue_o}, {1'b0, hs_pat, 1'b1, 12'h000});
            end
        end
        for (int y = 1; y < 166; y++) begin
            drive(1'b1, 1'b1, 1'b1);
            vectors++;
            if ({de_o, red_o, green_o, blue_o} !== {1'b1, hband3(y)}) begin
                miscompares++;
                $display("FAIL post_reset_y y=%0d: got %h want %h", y, {de_o, red_o, green_o, blue_o}, {1'b1, hband3(y)});
            end
            vectors++;
            if ({de7, red7, green7, blue7} !== {1'b1, hband7(y)}) begin
                miscompares++;
                $display("FAIL post_reset_y7 y=%0d: got %h want %h", y, {de7, red7, green7, blue7}, {1'b1, hband7(y)});
            end
            for (int x = 1; x < 8; x++) drive(1'b1, 1'b1, 1'b1);
            hblank();
        end
    endtask

    initial begin
        rst    = 1'b1;
        mode_i = 2'd0;
        de_i   = 1'b0;
        hs_i   = 1'b1;
        vs_i   = 1'b1;
        test_reset();
        test_hbands();
        test_vbands();
        test_checker();
        test_gradient();
        test_mode_midframe();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
